snn_core_tdm: RTL
=================

// Module: snn_core_tdm
// PURPOSE
//  Time-stepped leaky integrate-and-fire core: N neurons, M external input lines.
//  Synaptic weights live in a writable (N x (N+M)) register file.
//  Sources are scanned one per cycle; each spiking source's weight column is added to all N membranes in parallel.
//  Successor to the fully-parallel core: adds external inputs, leak, refractory period, step handshake, runtime weights.
// PARAMETERS
//  N           16  neuron count (>=2)
//  M           8   external input spike lines (>=1)
//  W           8   signed weight width
//  V_WIDTH     16  signed membrane width (> W)
//  LEAK_SHIFT  3   leak = v >>> LEAK_SHIFT per step (1..V_WIDTH-1)
//  REFRAC      2   refractory steps after a fire (0 = none)
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous active-high reset
//  step_valid    in   1                  request one timestep
//  step_ready    out  1                  high only in IDLE
//  in_spikes     in   M                  external spikes, sampled on step accept
//  threshold     in   V_WIDTH            signed fire threshold, sampled on step accept
//  wr_en         in   1                  weight write strobe
//  wr_row        in   $clog2(N)          target neuron
//  wr_col        in   $clog2(N+M)        source: 0..N-1 neuron, N..N+M-1 external
//  wr_data       in   W                  signed weight
//  spikes        out  N                  registered spikes of the last completed step
//  done          out  1                  1-cycle pulse: spikes updated
// BEHAVIOUR
//  Reset: state=IDLE, weights=0, membranes=0, refractory counters=0, spikes=0, done=0, step_ready=1.
//  Reset mid-step: same as reset. The step is abandoned; no done pulse.
//  FSM IDLE -> ACCUM -> UPDATE -> DONE -> IDLE.
//  Step accept: step_valid & step_ready at cycle 0.
//   Latch in_spikes, threshold, and prev = spikes (recurrent sources use the previous step's spikes).
//  ACCUM: cycles 1..N+M, source s = cycle-1. If source s spiked, each non-refractory neuron i does v_i = sat(v_i + sext(w[i][s])).
//  UPDATE (cycle N+M+1), per neuron:
//   If refrac_i>0: v_i=0, refrac_i--, spike_i=0.
//   Else: v'=sat(v_i - (v_i>>>LEAK_SHIFT)).
//    If v' >= threshold (signed): spike_i=1, v_i=0, refrac_i=REFRAC.
//    Else: spike_i=0, v_i=v'.
//  DONE (cycle N+M+2): spikes register holds new values; done=1.
//   Next cycle IDLE, step_ready=1. Accept-to-done latency = N+M+2 cycles.
//  sat(): clamp to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1]; never wraps. >>> rounds toward -inf.
//  step_valid while not IDLE: ignored (not queued).
//  Weight writes: applied only while IDLE, one per cycle; wr_en outside IDLE is dropped.
//   wr_col >= N+M or wr_row >= N: ignored.
//   Write on the same cycle as accept: applied, visible to that step.
//  spikes held stable between done pulses; membranes persist across steps.
// TESTING (N=4, M=2, W=8, V_WIDTH=16, LEAK_SHIFT=3, REFRAC=2, threshold=100)
//  Reset: spikes=0, done=0, step_ready=1.
//   Any step with no writes -> done exactly 8 cycles after accept, spikes=0.
//  Integration: w[0][4]=60, in_spikes=01 every step.
//   Steps 1,2 -> v0=53, 99, no spike. Step 3 -> 159-19=140, spikes[0]=1.
//  Refractory: w[1][4]=127, in_spikes=01 each step.
//   Step 1 spikes[1]=1 (112). Steps 2,3 spikes[1]=0. Step 4 spikes[1]=1.
//  Recurrence: w[1][5]=127, w[2][1]=120, in_spikes=10.
//   Step 1 spikes=0010. Step 2 spikes[2]=1 (120-15=105) via previous-step spike.
//  Handshake: step_valid held high through busy -> exactly one done per accept.
//   wr_en w[3][4]=127 during ACCUM -> dropped; next step with in_spikes=01 gives spikes[3]=0.
//  Reset at cycle 3 of a step: no done.
//   Next cycle step_ready=1, spikes=0, all weights read back as effect-free 0.

Source files
------------

// File: rtl/snn_core_tdm_if.sv
// Step handshake, weight-write port and spike outputs of the TDM
// integrate-and-fire core.
interface snn_core_tdm_if #(
    parameter int N       = 16,
    parameter int M       = 8,
    parameter int W       = 8,
    parameter int V_WIDTH = 16
);
    logic                     step_valid;
    logic                     step_ready;
    logic [M-1:0]             in_spikes;
    logic signed [V_WIDTH-1:0] threshold;
    logic                     wr_en;
    logic [$clog2(N)-1:0]     wr_row;
    logic [$clog2(N+M)-1:0]   wr_col;
    logic signed [W-1:0]      wr_data;
    logic [N-1:0]             spikes;
    logic                     done;

    modport master (
        output step_valid, in_spikes, threshold,
        output wr_en, wr_row, wr_col, wr_data,
        input  step_ready, spikes, done
    );

    modport slave (
        input  step_valid, in_spikes, threshold,
        input  wr_en, wr_row, wr_col, wr_data,
        output step_ready, spikes, done
    );
endinterface

// File: rtl/snn_core_tdm.sv
// Time-multiplexed leaky integrate-and-fire core: one source per cycle,
// the spiking source's weight column is added to every membrane at once.
module snn_core_tdm #(
    parameter int N          = 16,
    parameter int M          = 8,
    parameter int W          = 8,
    parameter int V_WIDTH    = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input logic         clk,
    input logic         rst,
    snn_core_tdm_if.slave bus
);
    localparam int S  = N + M;
    localparam int CW = $clog2(S);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [V_WIDTH:0] VMAX = {2'b00, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH:0] VMIN = {2'b11, {(V_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    state_t state, state_nx;

    logic signed [W-1:0]       w      [N][S];
    logic signed [V_WIDTH-1:0] v      [N];
    logic [RW-1:0]             refrac [N];
    logic [CW-1:0]             cnt;
    logic [M-1:0]              in_lat;
    logic [N-1:0]              prev;
    logic signed [V_WIDTH-1:0] thr;
    logic [N-1:0]              spk;
    logic                      accept;
    logic                      wr_ok;
    logic [S-1:0]              src;

    function automatic logic signed [V_WIDTH-1:0] sat(
        input logic signed [V_WIDTH:0] x
    );
        if (x > VMAX) return VMAX[V_WIDTH-1:0];
        if (x < VMIN) return VMIN[V_WIDTH-1:0];
        return x[V_WIDTH-1:0];
    endfunction

    function automatic logic signed [V_WIDTH-1:0] add_w(
        input logic signed [V_WIDTH-1:0] a,
        input logic signed [W-1:0]       b
    );
        logic signed [V_WIDTH:0] s;
        s = $signed({a[V_WIDTH-1], a}) +
            $signed({{(V_WIDTH+1-W){b[W-1]}}, b});
        return sat(s);
    endfunction

    function automatic logic signed [V_WIDTH-1:0] leak(
        input logic signed [V_WIDTH-1:0] a
    );
        logic signed [V_WIDTH-1:0] sh;
        logic signed [V_WIDTH:0]   d;
        sh = a >>> LEAK_SHIFT;
        d  = $signed({a[V_WIDTH-1], a}) - $signed({sh[V_WIDTH-1], sh});
        return sat(d);
    endfunction

    assign accept = bus.step_valid && (state == IDLE);
    assign wr_ok  = bus.wr_en && (state == IDLE) &&
                    (int'(bus.wr_row) < N) && (int'(bus.wr_col) < S);
    assign src    = {in_lat, prev};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.step_ready = 1'b0;
        bus.done       = 1'b0;
        unique case (state)
            IDLE: begin
                bus.step_ready = 1'b1;
                if (bus.step_valid) state_nx = ACCUM;
            end
            ACCUM:  if (cnt == CW'(S - 1)) state_nx = UPDATE;
            UPDATE: state_nx = DONE;
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.spikes = spk;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < S; j++) w[i][j] <= '0;
                v[i]      <= '0;
                refrac[i] <= '0;
            end
            cnt    <= '0;
            in_lat <= '0;
            prev   <= '0;
            thr    <= '0;
            spk    <= '0;
        end else begin
            if (wr_ok) w[bus.wr_row][bus.wr_col] <= bus.wr_data;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        in_lat <= bus.in_spikes;
                        thr    <= bus.threshold;
                        prev   <= spk;
                        cnt    <= '0;
                    end
                end
                ACCUM: begin
                    if (src[cnt]) begin
                        for (int i = 0; i < N; i++)
                            if (refrac[i] == '0)
                                v[i] <= add_w(v[i], w[i][cnt]);
                    end
                    cnt <= cnt + 1'b1;
                end
                UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        if (refrac[i] != '0) begin
                            v[i]      <= '0;
                            refrac[i] <= refrac[i] - 1'b1;
                            spk[i]    <= 1'b0;
                        end else if (leak(v[i]) >= thr) begin
                            v[i]      <= '0;
                            refrac[i] <= RW'(REFRAC);
                            spk[i]    <= 1'b1;
                        end else begin
                            v[i]   <= leak(v[i]);
                            spk[i] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
